ram_arb2: RTL and testbench
===========================

RAM_ARB2 -- requirements
Module: ram_arb2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have, per requester n in {0,1}, these request ports:
- mn_req_valid_i, input, 1, request valid.
- mn_req_ready_o, output, 1, request accepted this cycle.
- mn_we_i, input, 1, write request when 1, read when 0.
- mn_we_mask_i, input, 4, byte write mask.
- mn_addr_i, input, ADDR_WIDTH, byte address.
- mn_data_i, input, DATA_WIDTH, write data.
REQ-006 SHALL have, per requester n in {0,1}, these response ports:
- mn_rsp_valid_o, output, 1, response valid.
- mn_rsp_ready_i, input, 1, response consumed.
- mn_rsp_data_o, output, DATA_WIDTH, read data; 0 for write responses.
REQ-007 SHALL have these RAM-side ports, connected to the shared single-port RAM, which has combinational read and a synchronous byte-masked write:
- ram_we_o, output, 1, RAM write enable.
- ram_we_mask_o, output, 4, RAM byte mask.
- ram_addr_o, output, ADDR_WIDTH, RAM byte address.
- ram_data_o, output, DATA_WIDTH, RAM write data.
- ram_data_i, input, DATA_WIDTH, RAM read data.

Function
REQ-008 SHALL treat a request as transferred when mn_req_valid_i and mn_req_ready_o are both 1 on a rising edge; at most one transfer per cycle across both ports.
REQ-009 SHALL hold one response register per port: rsp_valid, rsp_data.
- Port n is eligible when mn_req_valid_i=1 and (rsp_valid_n=0 or mn_rsp_ready_i=1).
REQ-010 SHALL keep a 1-bit priority pointer prio with states PRI0 (port 0 favoured) and PRI1 (port 1 favoured).
- If only one port is eligible, that port is granted.
- If both ports are eligible, the favoured port is granted.
- If neither port is eligible, there is no grant.
REQ-011 SHALL drive mn_req_ready_o=1 only for the granted port, combinationally, within the same cycle.
REQ-012 SHALL move prio, on each transfer, to favour the non-granted port (grant 0 -> PRI1, grant 1 -> PRI0); with no transfer, prio SHALL hold.
REQ-013 SHALL drive the RAM ports from the granted port's address, write enable, mask and data.
- ram_we_o = granted port's mn_we_i AND a grant exists.
- With no grant: ram_we_o=0, ram_we_mask_o=0, and ram_addr_o/ram_data_o hold the port-0 inputs.
REQ-014 SHALL load the granted port's response register on a transfer:
- rsp_valid=1.
- rsp_data = ram_data_i sampled in the grant cycle for a read, or 0 for a write.
- The response is visible exactly one cycle after the transfer.
REQ-015 SHALL return pre-write RAM contents on a same-cycle read of an address being written, because the read is combinational and the write lands at the edge.
REQ-016 SHALL clear a port's rsp_valid when mn_rsp_ready_i=1 and rsp_valid=1 with no new transfer on that port.
- When consume and a new transfer coincide, the new response SHALL replace the old one, giving back-to-back throughput of 1 per cycle per port.
REQ-017 SHALL hold rsp_valid and rsp_data stable while mn_rsp_ready_i=0.
REQ-018 SHALL not alter RAM contents or state except through a transfer; request inputs with valid=0 are ignored.

Reset
REQ-019 SHALL, while rst=1 at an edge, set rsp_valid=0 and rsp_data=0 on both ports and prio=PRI0.
REQ-020 SHALL force mn_req_ready_o=0 and ram_we_o=0 combinationally while rst=1, so no RAM write occurs during reset.
REQ-021 SHALL discard an in-flight response on mid-operation reset, with m0_rsp_valid_o=m1_rsp_valid_o=0 in the first cycle after reset deasserts.

Verification
REQ-022 SHALL pass a single read: RAM word at 0x0010 = 0xDEADBEEF, m0 read 0x0010 -> m0_req_ready_o=1 same cycle, m0_rsp_valid_o=1 with data 0xDEADBEEF next cycle.
REQ-023 SHALL pass contention: both ports hold valid reads, rsp_ready=1, for 4 cycles from reset -> grants 0,1,0,1, and ram_we_o is never asserted.
REQ-024 SHALL pass a masked write: m1 write 0x0020, mask 4'b0011, data 0x12345678 over word 0xAAAAAAAA -> m1 read 0x0020 returns 0xAAAA5678, and the write response data is 0.
REQ-025 SHALL pass backpressure: m0 rsp_ready=0 with a response pending, m0 valid, m1 idle -> m0_req_ready_o=0 and the response is held stable; rsp_ready=1 -> the new request is accepted that cycle.
REQ-026 SHALL pass reset mid-operation: rst=1 the cycle after an m1 transfer -> m1_rsp_valid_o=0 after reset, prio=PRI0, and the next simultaneous request grants m0.
REQ-027 SHALL pass write-then-read to the same address on consecutive cycles (m0 write, m1 read) -> the m1 response returns the new data.

Source files
------------

// File: rtl/ram_arb2.sv
// Two-port round-robin arbiter in front of a shared single-port RAM with combinational read.
// Each port owns a one-deep response register, so a port with a consumed response streams 1/cycle.
module ram_arb2 #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0
  input  logic                  m0_req_valid_i,
  output logic                  m0_req_ready_o,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_we_mask_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic                  m0_rsp_valid_o,
  input  logic                  m0_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] m0_rsp_data_o,
  // requester 1
  input  logic                  m1_req_valid_i,
  output logic                  m1_req_ready_o,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_we_mask_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic                  m1_rsp_valid_o,
  input  logic                  m1_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] m1_rsp_data_o,
  // shared RAM
  output logic                  ram_we_o,
  output logic [3:0]            ram_we_mask_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i
);

  typedef enum logic {Pri0, Pri1} prio_e;

  prio_e                 prio_q, prio_d;
  logic                  rsp_valid0_q, rsp_valid0_d;
  logic                  rsp_valid1_q, rsp_valid1_d;
  logic [DATA_WIDTH-1:0] rsp_data0_q, rsp_data0_d;
  logic [DATA_WIDTH-1:0] rsp_data1_q, rsp_data1_d;

  logic elig0, elig1;
  logic grant0, grant1;

  // A port may only be granted if its response slot is free or drains this same cycle.
  assign elig0 = m0_req_valid_i && (!rsp_valid0_q || m0_rsp_ready_i);
  assign elig1 = m1_req_valid_i && (!rsp_valid1_q || m1_rsp_ready_i);

  assign grant0 = !rst && elig0 && (!elig1 || (prio_q == Pri0));
  assign grant1 = !rst && elig1 && (!elig0 || (prio_q == Pri1));

  assign m0_req_ready_o = grant0;
  assign m1_req_ready_o = grant1;

  // Without a grant the RAM address/data still follow port 0, but nothing is written.
  always_comb begin
    ram_we_o      = 1'b0;
    ram_we_mask_o = 4'b0000;
    ram_addr_o    = m0_addr_i;
    ram_data_o    = m0_data_i;
    if (grant1) begin
      ram_we_o      = m1_we_i;
      ram_we_mask_o = m1_we_mask_i;
      ram_addr_o    = m1_addr_i;
      ram_data_o    = m1_data_i;
    end else if (grant0) begin
      ram_we_o      = m0_we_i;
      ram_we_mask_o = m0_we_mask_i;
    end
  end

  always_comb begin
    prio_d       = prio_q;
    rsp_valid0_d = rsp_valid0_q;
    rsp_valid1_d = rsp_valid1_q;
    rsp_data0_d  = rsp_data0_q;
    rsp_data1_d  = rsp_data1_q;

    unique case (prio_q)
      Pri0: if (grant0) prio_d = Pri1;
            else if (grant1) prio_d = Pri0;
      Pri1: if (grant1) prio_d = Pri0;
            else if (grant0) prio_d = Pri1;
      default: prio_d = Pri0;
    endcase

    // A new transfer overwrites a response being consumed in the same cycle.
    if (grant0) begin
      rsp_valid0_d = 1'b1;
      rsp_data0_d  = m0_we_i ? '0 : ram_data_i;
    end else if (m0_rsp_ready_i && rsp_valid0_q) begin
      rsp_valid0_d = 1'b0;
    end

    if (grant1) begin
      rsp_valid1_d = 1'b1;
      rsp_data1_d  = m1_we_i ? '0 : ram_data_i;
    end else if (m1_rsp_ready_i && rsp_valid1_q) begin
      rsp_valid1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q       <= Pri0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_data0_q  <= '0;
      rsp_data1_q  <= '0;
    end else begin
      prio_q       <= prio_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_data0_q  <= rsp_data0_d;
      rsp_data1_q  <= rsp_data1_d;
    end
  end

  assign m0_rsp_valid_o = rsp_valid0_q;
  assign m1_rsp_valid_o = rsp_valid1_q;
  assign m0_rsp_data_o  = rsp_data0_q;
  assign m1_rsp_data_o  = rsp_data1_q;

endmodule

// File: tb/tb_ram_arb2.sv
// Bench for ram_arb2: directed scenarios plus random traffic, checked against a
// transaction-level model of arbitration, response slots and RAM contents.
module tb_ram_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clear;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [3:0]  req_mask  [2];
  logic [15:0] req_addr  [2];
  logic [31:0] req_data  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];

  logic        ram_we;
  logic [3:0]  ram_we_mask;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [64];

  // Reference model state
  logic [31:0] ref_mem [64];
  int          ref_prio;
  logic        ref_rv [2];
  logic        ref_dv [2];
  logic [31:0] ref_rd [2];
  int          last_grant;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_arb2 #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .m0_req_valid_i (req_valid[0]),
    .m0_req_ready_o (req_ready[0]),
    .m0_we_i        (req_we[0]),
    .m0_we_mask_i   (req_mask[0]),
    .m0_addr_i      (req_addr[0]),
    .m0_data_i      (req_data[0]),
    .m0_rsp_valid_o (rsp_valid[0]),
    .m0_rsp_ready_i (rsp_ready[0]),
    .m0_rsp_data_o  (rsp_data[0]),
    .m1_req_valid_i (req_valid[1]),
    .m1_req_ready_o (req_ready[1]),
    .m1_we_i        (req_we[1]),
    .m1_we_mask_i   (req_mask[1]),
    .m1_addr_i      (req_addr[1]),
    .m1_data_i      (req_data[1]),
    .m1_rsp_valid_o (rsp_valid[1]),
    .m1_rsp_ready_i (rsp_ready[1]),
    .m1_rsp_data_o  (rsp_data[1]),
    .ram_we_o       (ram_we),
    .ram_we_mask_o  (ram_we_mask),
    .ram_addr_o     (ram_addr),
    .ram_data_o     (ram_wdata),
    .ram_data_i     (ram_rdata)
  );

  // Shared RAM: combinational read, byte-masked write at the edge.
  assign ram_rdata = mem[ram_addr[7:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we_mask[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One clock cycle with the currently driven inputs.
  task automatic step();
    int g;
    logic e0, e1;
    int idx;
    #1;
    e0 = req_valid[0] && (!ref_rv[0] || rsp_ready[0]);
    e1 = req_valid[1] && (!ref_rv[1] || rsp_ready[1]);
    if (rst)            g = -1;
    else if (e0 && e1)  g = ref_prio;
    else if (e0)        g = 0;
    else if (e1)        g = 1;
    else                g = -1;

    check_eq("ready0", 64'(req_ready[0]), 64'(g == 0));
    check_eq("ready1", 64'(req_ready[1]), 64'(g == 1));
    check_eq("ram_we", 64'(ram_we), (g >= 0) ? 64'(req_we[g]) : 64'd0);
    check_eq("ram_mask", 64'(ram_we_mask), (g >= 0) ? 64'(req_mask[g]) : 64'd0);
    check_eq("ram_addr", 64'(ram_addr), (g >= 0) ? 64'(req_addr[g]) : 64'(req_addr[0]));
    check_eq("ram_data", 64'(ram_wdata), (g >= 0) ? 64'(req_data[g]) : 64'(req_data[0]));

    @(posedge clk);
    if (rst) begin
      ref_prio = 0;
      for (int n = 0; n < 2; n++) begin
        ref_rv[n] = 1'b0;
        ref_dv[n] = 1'b1;
        ref_rd[n] = '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (g == n) begin
          idx = int'(req_addr[n][7:2]);
          ref_rv[n] = 1'b1;
          ref_dv[n] = 1'b1;
          ref_rd[n] = req_we[n] ? 32'd0 : ref_mem[idx];
        end else if (rsp_ready[n] && ref_rv[n]) begin
          ref_rv[n] = 1'b0;
          ref_dv[n] = 1'b0;
        end
      end
      if (g >= 0) begin
        idx = int'(req_addr[g][7:2]);
        if (req_we[g]) ref_mem[idx] = merge(ref_mem[idx], req_data[g], req_mask[g]);
        ref_prio = 1 - g;
      end
    end
    last_grant = g;
    #1;
    for (int n = 0; n < 2; n++) begin
      check_eq(n == 0 ? "rsp_valid0" : "rsp_valid1", 64'(rsp_valid[n]), 64'(ref_rv[n]));
      if (ref_dv[n])
        check_eq(n == 0 ? "rsp_data0" : "rsp_data1", 64'(rsp_data[n]), 64'(ref_rd[n]));
    end
  endtask

  task automatic set_idle();
    for (int n = 0; n < 2; n++) begin
      req_valid[n] = 1'b0;
      req_we[n]    = 1'b0;
      req_mask[n]  = 4'h0;
      req_addr[n]  = 16'h0;
      req_data[n]  = 32'h0;
      rsp_ready[n] = 1'b1;
    end
  endtask

  task automatic drive(input int n, input logic w, input logic [3:0] m,
                       input logic [15:0] a, input logic [31:0] d);
    req_valid[n] = 1'b1;
    req_we[n]    = w;
    req_mask[n]  = m;
    req_addr[n]  = a;
    req_data[n]  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    ref_prio   = 0;
    last_grant = -1;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    for (int n = 0; n < 2; n++) begin
      ref_rv[n] = 1'b0;
      ref_dv[n] = 1'b0;
      ref_rd[n] = '0;
    end
    set_idle();
    rst = 1'b1;
    mem_clear = 1'b1;
    step();
    mem_clear = 1'b0;
    step();
    rst = 1'b0;
    check_eq("reset_valid0", 64'(rsp_valid[0]), 64'd0);
    check_eq("reset_data1", 64'(rsp_data[1]), 64'd0);

    // Single read of a preloaded word
    drive(0, 1'b1, 4'hf, 16'h0010, 32'hDEADBEEF);
    step();
    set_idle();
    drive(0, 1'b0, 4'h0, 16'h0010, 32'h0);
    step();
    check_eq("single_read_grant", 64'(last_grant), 64'd0);
    check_eq("single_read_data", 64'(rsp_data[0]), 64'hDEADBEEF);
    set_idle();
    step();

    // Contention from reset alternates grants
    do_reset();
    drive(0, 1'b0, 4'h0, 16'h0010, 32'h0);
    drive(1, 1'b0, 4'h0, 16'h0014, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("contend_grant", 64'(last_grant), 64'(k % 2));
    end
    set_idle();

    // Masked write then read back
    drive(0, 1'b1, 4'hf, 16'h0020, 32'hAAAAAAAA);
    step();
    set_idle();
    drive(1, 1'b1, 4'b0011, 16'h0020, 32'h12345678);
    step();
    check_eq("mwrite_rsp_data", 64'(rsp_data[1]), 64'd0);
    drive(1, 1'b0, 4'h0, 16'h0020, 32'h0);
    step();
    check_eq("mwrite_readback", 64'(rsp_data[1]), 64'hAAAA5678);
    set_idle();
    step();

    // Backpressure on port 0
    drive(0, 1'b0, 4'h0, 16'h0010, 32'h0);
    rsp_ready[0] = 1'b0;
    step();
    held = rsp_data[0];
    step();
    check_eq("bp_no_grant", 64'(last_grant), 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("bp_held_data", 64'(rsp_data[0]), 64'(held));
    check_eq("bp_held_valid", 64'(rsp_valid[0]), 64'd1);
    rsp_ready[0] = 1'b1;
    step();
    check_eq("bp_accept", 64'(last_grant), 64'd0);
    set_idle();

    // Reset mid-operation after an m1 transfer, then after an m0 transfer
    for (int k = 0; k < 2; k++) begin
      drive(1 - k, 1'b0, 4'h0, 16'h0010, 32'h0);
      step();
      set_idle();
      do_reset();
      check_eq("midrst_valid", 64'(rsp_valid[1 - k]), 64'd0);
      drive(0, 1'b0, 4'h0, 16'h0010, 32'h0);
      drive(1, 1'b0, 4'h0, 16'h0020, 32'h0);
      step();
      check_eq("midrst_grant", 64'(last_grant), 64'd0);
      set_idle();
      step();
    end

    // Write by m0 then read by m1 on the next cycle
    drive(0, 1'b1, 4'hf, 16'h0030, 32'hCAFEF00D);
    step();
    set_idle();
    drive(1, 1'b0, 4'h0, 16'h0030, 32'h0);
    step();
    check_eq("wr_rd_data", 64'(rsp_data[1]), 64'hCAFEF00D);
    set_idle();
    step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom % 64) == 0;
      for (int n = 0; n < 2; n++) begin
        req_valid[n] = ($urandom % 3) != 0;
        req_we[n]    = $urandom % 2;
        req_mask[n]  = 4'($urandom);
        req_addr[n]  = 16'($urandom_range(0, 255));
        req_data[n]  = $urandom;
        rsp_ready[n] = ($urandom % 4) != 0;
      end
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
